somador_32bit: RTL and testbench
================================

Name: somador_32bit

Overview:
- WIDTH-bit unsigned ripple-carry adder: two operands in, sum and carry-out produced combinationally.
- A registered copy of the result, qualified by a valid flag, is also provided for pipelined consumers.
- Sits in the ULA (ALU) datapath as its add unit.

Parameters:
- WIDTH, 32, operand and sum width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock; used only by the registered result stage.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- in_valid  input  1  marks a/b as valid for capture into the registered stage.
- s  output  WIDTH  combinational sum, (a+b) mod 2^WIDTH.
- cout  output  1  combinational carry-out, bit WIDTH of a+b.
- s_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- out_valid  output  1  registered in_valid; qualifies s_q/cout_q.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Combinational path:
  - {cout, s} == a + b as an exact WIDTH+1-bit result, for all input values.
  - Built as a ripple chain of WIDTH 1-bit full adders; carry-in to bit 0 is constant 0.
  - No dependency on clk or rst_n.
  - Must settle within 1 ns of any input change in simulation; zero-delay RTL is acceptable.
- Full-adder cell: sum = x^y^ci; co = (x&y) | (ci&(x^y)).
- Registered path:
  - On each clk rising edge, s_q <= s, cout_q <= cout, out_valid <= in_valid.
  - s_q/cout_q load every cycle regardless of in_valid; only out_valid carries qualification.
  - Latency is 1 cycle; no backpressure; a new operand pair is accepted every cycle.
- Reset:
  - rst_n low immediately forces s_q = 0, cout_q = 0, out_valid = 0, independent of clk.
  - Asserting reset mid-operation discards any in-flight result.
  - On release, the first capture occurs at the next rising edge.
  - Combinational s/cout keep tracking a+b during reset.
- Boundary conditions:
  - 0+0 -> s = 0, cout = 0.
  - Max+1 wraps: s = 0, cout = 1.
  - Max+Max -> s = 2^WIDTH-2, cout = 1.
- X propagation: an X on any operand bit may corrupt that bit and everything above it; no X-masking.

Optional Feature:
- Macro SOMADOR_OVERFLOW_EN.
- When defined, add outputs:
  - ovf (1 bit, combinational): ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), the two's-complement signed overflow.
  - ovf_q (1 bit, registered): same capture/reset rules as cout_q; reset value 0.
- When undefined, these ports and the associated logic are absent; all other behaviour is identical.

Decomposition:
- Package somador_pkg holds:
  - localparam SOMADOR_WIDTH = 32 (default for WIDTH);
  - a typedef for the WIDTH-bit operand/sum vector;
  - a typedef for the WIDTH+1-bit extended result.
- One sub-module: somador_1bit, the full-adder cell (inputs x, y, ci; outputs sum, co).
  - Instantiated WIDTH times through a generate loop, with the carry chained between cells.

Test Plan:
- Exhaustive low range: a, b each swept 0..16383, one pair every 10 ns. Check {cout, s} === a+b 1 ns after each change -> zero mismatches.
- Corners:
  - 0xFFFFFFFF + 0x00000001 -> s = 0x00000000, cout = 1.
  - 0xFFFFFFFF + 0xFFFFFFFF -> s = 0xFFFFFFFE, cout = 1.
  - 0x80000000 + 0x80000000 -> s = 0, cout = 1.
- Carry propagation: 0x7FFFFFFF + 1 -> s = 0x80000000, cout = 0. With SOMADOR_OVERFLOW_EN defined, ovf = 1.
- Registered path: in_valid = 1, a = 5, b = 7 at edge N -> s_q = 12, cout_q = 0, out_valid = 1 after edge N; in_valid = 0 at edge N+1 -> out_valid = 0.
- Async reset: pull rst_n low between clock edges while out_valid = 1 -> s_q, cout_q and out_valid go to 0 immediately; s still equals a+b.
- Random: 10^6 random 32-bit pairs -> combinational and registered outputs match the reference model a+b with zero mismatches.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared width default and vector types for the somador_32bit adder.
`timescale 1ns/1ps
package somador_pkg;

    localparam int SOMADOR_WIDTH = 32;

    typedef logic [SOMADOR_WIDTH-1:0] somador_word_t;
    typedef logic [SOMADOR_WIDTH:0]   somador_ext_t;

endpackage

// File: rtl/somador_1bit.sv
// One-bit full-adder cell used as a link in the ripple-carry chain.
`timescale 1ns/1ps
module somador_1bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic sum,
    output logic co
);

    logic p;

    assign p   = x ^ y;
    assign sum = p ^ ci;
    assign co  = (x & y) | (ci & p);

endmodule

// File: rtl/somador_32bit.sv
// Ripple-carry unsigned adder with a one-cycle registered copy of the result.
// Optional signed-overflow outputs ovf/ovf_q are built when SOMADOR_OVERFLOW_EN is defined.
`timescale 1ns/1ps
module somador_32bit
    import somador_pkg::*;
#(
    parameter int WIDTH = SOMADOR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             out_valid
`ifdef SOMADOR_OVERFLOW_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;
    logic             valid_d;
    logic             valid_q;

    assign carry[0] = 1'b0;

    for (genvar gen_bit = 0; gen_bit < WIDTH; gen_bit++) begin : gen_fa
        somador_1bit u_fa (
            .x   (a[gen_bit]),
            .y   (b[gen_bit]),
            .ci  (carry[gen_bit]),
            .sum (s[gen_bit]),
            .co  (carry[gen_bit+1])
        );
    end

    assign cout = carry[WIDTH];

`ifdef SOMADOR_OVERFLOW_EN
    logic ovf_d;

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
`endif

    // The result stage loads every cycle; only the valid flag qualifies it.
    always_comb begin
        s_d     = s;
        cout_d  = cout;
        valid_d = in_valid;
`ifdef SOMADOR_OVERFLOW_EN
        ovf_d   = ovf;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SOMADOR_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef SOMADOR_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign out_valid = valid_q;

endmodule

// File: tb/tb_somador_32bit.sv
// Self-checking bench for somador_32bit: reference model plus directed literal vectors.
`timescale 1ns/1ps
module tb_somador_32bit;
    import somador_pkg::*;

    logic          clk;
    logic          rst_n;
    somador_word_t a;
    somador_word_t b;
    logic          in_valid;
    somador_word_t s;
    logic          cout;
    somador_word_t s_q;
    logic          cout_q;
    logic          out_valid;
`ifdef SOMADOR_OVERFLOW_EN
    logic          ovf;
    logic          ovf_q;
`endif

    int total = 0;
    int bad   = 0;
    logic cmp_en = 1'b0;

    somador_32bit #(.WIDTH(SOMADOR_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .s_q       (s_q),
        .cout_q    (cout_q),
        .out_valid (out_valid)
`ifdef SOMADOR_OVERFLOW_EN
        ,
        .ovf       (ovf),
        .ovf_q     (ovf_q)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: exact sum as a 64-bit integer, signed overflow from signed range.
    function automatic longint unsigned ref_sum(input somador_word_t x, input somador_word_t y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        return ux + uy;
    endfunction

    function automatic logic ref_ovf(input somador_word_t x, input somador_word_t y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r  = sx + sy;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Expected registered state.
    longint unsigned m_sum;
    logic            m_valid;
    logic            m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum   = 0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_sum   = ref_sum(a, b);
            m_valid = in_valid;
            m_ovf   = ref_ovf(a, b);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("comb_sum", {31'b0, cout, s}, ref_sum(a, b));
            check("reg_sum", {31'b0, cout_q, s_q}, m_sum);
            check("reg_valid", {63'b0, out_valid}, {63'b0, m_valid});
`ifdef SOMADOR_OVERFLOW_EN
            check("comb_ovf", {63'b0, ovf}, {63'b0, ref_ovf(a, b)});
            check("reg_ovf", {63'b0, ovf_q}, {63'b0, m_ovf});
`endif
        end
    end

    task automatic drive(input somador_word_t xa, input somador_word_t xb, input logic v);
        @(posedge clk);
        #2;
        a        = xa;
        b        = xb;
        in_valid = v;
        #1;
    endtask

    task automatic lit(input string name, input somador_word_t es, input logic ec);
        check(name, {31'b0, cout, s}, {31'b0, ec, es});
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        #1;
        check("rst_s_q", {32'b0, s_q}, 64'd0);
        check("rst_cout_q", {63'b0, cout_q}, 64'd0);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_comb", {31'b0, cout, s}, 64'd0);

        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        drive(32'h0000_0000, 32'h0000_0000, 1'b1);
        lit("zero_plus_zero", 32'h0000_0000, 1'b0);
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        lit("max_plus_one", 32'h0000_0000, 1'b1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        lit("max_plus_max", 32'hFFFF_FFFE, 1'b1);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0);
        lit("msb_plus_msb", 32'h0000_0000, 1'b1);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
        lit("carry_ripple", 32'h8000_0000, 1'b0);
`ifdef SOMADOR_OVERFLOW_EN
        check("ovf_literal", {63'b0, ovf}, 64'd1);
`endif
        drive(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        lit("mixed_bits", 32'h2222_2221, 1'b0);

        // Registered path: capture at edge N, valid drops after edge N+1.
        drive(32'd5, 32'd7, 1'b1);
        @(posedge clk);
        #1;
        check("reg_12_sum", {32'b0, s_q}, 64'd12);
        check("reg_12_cout", {63'b0, cout_q}, 64'd0);
        check("reg_12_valid", {63'b0, out_valid}, 64'd1);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reg_valid_drop", {63'b0, out_valid}, 64'd0);
        check("reg_12_hold", {32'b0, s_q}, 64'd12);

        // Asynchronous reset between edges while a valid result is held.
        drive(32'd3, 32'd4, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_valid", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_s_q", {32'b0, s_q}, 64'd0);
        check("arst_cout_q", {63'b0, cout_q}, 64'd0);
        check("arst_valid", {63'b0, out_valid}, 64'd0);
        lit("arst_comb", 32'd7, 1'b0);
        @(posedge clk);
        #1;
        check("arst_hold", {63'b0, out_valid}, 64'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_q", {32'b0, s_q}, 64'd7);
        check("post_rst_valid", {63'b0, out_valid}, 64'd1);

        // Low-range sweep.
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                drive(somador_word_t'(i), somador_word_t'(j), 1'(i ^ j));
            end
        end

        // Random operands, including sparse boundary-heavy patterns.
        for (int k = 0; k < 3000; k++) begin
            somador_word_t ra;
            somador_word_t rb;
            ra = $urandom;
            rb = $urandom;
            if (k % 7 == 0) ra = ra | 32'hFFFF_0000;
            if (k % 11 == 0) rb = ~ra;
            drive(ra, rb, 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
